dvfs_transition_sequencer: RTL and testbench

// Downstream of the DVFS OPP selector. Converts a requested operating point (opp/freq/volt)

---
 rtl/dvfs_pkg.sv | 23 ++
 rtl/dvfs_seq_timer.sv | 26 ++
 rtl/dvfs_transition_sequencer.sv | 158 +++++++++++++++
 tb/tb_dvfs_transition_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dvfs_pkg.sv
// Shared DVFS types and widths, used by the OPP selector and the transition sequencer.
package dvfs_pkg;

    localparam int unsigned OPP_W  = 3;
    localparam int unsigned FREQ_W = 32;
    localparam int unsigned VOLT_W = 16;

    typedef enum logic [2:0] {
        StIdle,
        StVUp,
        StVSettle,
        StFChg,
        StVDown,
        StDone
    } seq_state_t;

    typedef struct packed {
        logic [OPP_W-1:0]  opp;
        logic [FREQ_W-1:0] freq;
        logic [VOLT_W-1:0] volt;
    } opp_t;

endpackage

// File: rtl/dvfs_seq_timer.sv
// Loadable down-counter; expired is high during the last counted cycle.
module dvfs_seq_timer #(
    parameter int unsigned CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/dvfs_transition_sequencer.sv
// Orders regulator and PLL handshakes for an OPP change: volts up before freq up,
// freq down before volts down; gates the core clock while the PLL relocks.
module dvfs_transition_sequencer
    import dvfs_pkg::*;
#(
    parameter int unsigned       SETTLE_CYC  = 32,
    parameter int unsigned       TIMEOUT_CYC = 2048,
    parameter logic [OPP_W-1:0]  RST_OPP     = 3'd0,
    parameter logic [FREQ_W-1:0] RST_FREQ    = 32'd100_000_000,
    parameter logic [VOLT_W-1:0] RST_VOLT    = 16'd700
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OPP_W-1:0]  req_opp,
    input  logic [FREQ_W-1:0] req_freq,
    input  logic [VOLT_W-1:0] req_volt,
    output logic              vreg_req,
    output logic [VOLT_W-1:0] vreg_target,
    input  logic              vreg_ack,
    output logic              pll_req,
    output logic [FREQ_W-1:0] pll_freq,
    input  logic              pll_lock,
    output logic              clk_en,
    output logic [OPP_W-1:0]  cur_opp,
    output logic              busy,
    output logic              done,
    output logic              fault,
    input  logic              fault_clr
);

    localparam int unsigned MAX_CYC = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

    seq_state_t        state_q, state_d;
    opp_t              tgt_q, tgt_d;
    logic              start, timeout_hit, entering;
    logic              tmr_load, tmr_expired;
    logic [CNT_W-1:0]  tmr_val;

    logic              vreg_req_q, pll_req_q, clk_en_q, busy_q, done_q, fault_q;
    logic [VOLT_W-1:0] vreg_target_q;
    logic [FREQ_W-1:0] pll_freq_q;
    logic [OPP_W-1:0]  cur_opp_q;

    dvfs_seq_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tmr_load),
        .load_val(tmr_val),
        .expired (tmr_expired)
    );

    // A pending fault_clr wins over a new request for this cycle.
    assign start = (state_q == StIdle) && !fault_q && !fault_clr && (req_opp != cur_opp_q);

    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        timeout_hit = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = CNT_W'(TIMEOUT_CYC);
        if (start) begin
            tgt_d = '{opp: req_opp, freq: req_freq, volt: req_volt};
        end
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (req_volt > vreg_target_q)     state_d = StVUp;
                    else if (req_freq != pll_freq_q)  state_d = StFChg;
                    else if (req_volt < vreg_target_q) state_d = StVDown;
                    else                               state_d = StDone;
                end
            end
            StVUp: begin
                if (vreg_ack)         state_d = StVSettle;
                else if (tmr_expired) timeout_hit = 1'b1;
            end
            StVSettle: begin
                if (tmr_expired) state_d = (tgt_q.freq != pll_freq_q) ? StFChg : StDone;
            end
            StFChg: begin
                if (pll_lock)         state_d = (tgt_q.volt < vreg_target_q) ? StVDown : StDone;
                else if (tmr_expired) timeout_hit = 1'b1;
            end
            StVDown: begin
                if (vreg_ack)         state_d = StDone;
                else if (tmr_expired) timeout_hit = 1'b1;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (timeout_hit) state_d = StIdle;

        entering = (state_d != state_q);
        if (entering && (state_d inside {StVUp, StFChg, StVDown})) tmr_load = 1'b1;
        if (entering && (state_d == StVSettle)) begin
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(SETTLE_CYC);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            tgt_q         <= '{opp: RST_OPP, freq: RST_FREQ, volt: RST_VOLT};
            vreg_req_q    <= 1'b0;
            pll_req_q     <= 1'b0;
            clk_en_q      <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            fault_q       <= 1'b0;
            vreg_target_q <= RST_VOLT;
            pll_freq_q    <= RST_FREQ;
            cur_opp_q     <= RST_OPP;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            busy_q  <= (state_d != StIdle);
            done_q  <= (state_d == StDone);
            if (fault_clr && state_q == StIdle) fault_q <= 1'b0;
            if (timeout_hit)                    fault_q <= 1'b1;
            // Release handshakes on leaving a state; entry assignments below override.
            if (entering) begin
                if (state_q == StVUp || state_q == StVDown) vreg_req_q <= 1'b0;
                if (state_q == StFChg) begin
                    pll_req_q <= 1'b0;
                    clk_en_q  <= 1'b1;
                end
                unique case (state_d)
                    StVUp, StVDown: begin
                        vreg_target_q <= tgt_d.volt;
                        vreg_req_q    <= 1'b1;
                    end
                    StFChg: begin
                        pll_freq_q <= tgt_d.freq;
                        pll_req_q  <= 1'b1;
                        clk_en_q   <= 1'b0;
                    end
                    StDone:  cur_opp_q <= tgt_d.opp;
                    default: ;
                endcase
            end
        end
    end

    assign vreg_req    = vreg_req_q;
    assign vreg_target = vreg_target_q;
    assign pll_req     = pll_req_q;
    assign pll_freq    = pll_freq_q;
    assign clk_en      = clk_en_q;
    assign cur_opp     = cur_opp_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_dvfs_transition_sequencer.sv
// Directed bench for dvfs_transition_sequencer; inputs driven and outputs sampled on negedge.
module tb_dvfs_transition_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req_opp;
    logic [31:0] req_freq;
    logic [15:0] req_volt;
    logic        vreg_req, vreg_ack, pll_req, pll_lock, clk_en, busy, done, fault, fault_clr;
    logic [15:0] vreg_target;
    logic [31:0] pll_freq;
    logic [2:0]  cur_opp;

    int errors = 0;
    int checks = 0;

    dvfs_transition_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_opp    (req_opp),
        .req_freq   (req_freq),
        .req_volt   (req_volt),
        .vreg_req   (vreg_req),
        .vreg_target(vreg_target),
        .vreg_ack   (vreg_ack),
        .pll_req    (pll_req),
        .pll_freq   (pll_freq),
        .pll_lock   (pll_lock),
        .clk_en     (clk_en),
        .cur_opp    (cur_opp),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .fault_clr  (fault_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic test_reset();
        rst_n = 1'b0; req_opp = 3'd0; req_freq = 32'd100_000_000; req_volt = 16'd700;
        vreg_ack = 1'b0; pll_lock = 1'b0; fault_clr = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({vreg_req, pll_req, clk_en, busy, done, fault} !== 6'b001000) begin
            errors++; $display("FAIL reset_flags: got %b required 001000",
                               {vreg_req, pll_req, clk_en, busy, done, fault});
        end
        checks++;
        if (vreg_target !== 16'd700 || pll_freq !== 32'd100_000_000 || cur_opp !== 3'd0) begin
            errors++; $display("FAIL reset_values: got %0d/%0d/%0d required 700/100000000/0",
                               vreg_target, pll_freq, cur_opp);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_idle: busy got %b required 0", busy);
        end
    endtask

    task automatic test_up();
        req_opp = 3'd3; req_freq = 32'd600_000_000; req_volt = 16'd800;
        @(negedge clk);
        checks++;
        if ({vreg_req, pll_req, clk_en, busy, done} !== 5'b10110 || vreg_target !== 16'd800) begin
            errors++; $display("FAIL up_vreq: got %b/%0d required 10110/800",
                               {vreg_req, pll_req, clk_en, busy, done}, vreg_target);
        end
        repeat (4) @(negedge clk);
        vreg_ack = 1'b1;
        @(negedge clk);
        vreg_ack = 1'b0;
        checks++;
        if (vreg_req !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL up_ack: vreg_req/busy got %b%b required 01", vreg_req, busy);
        end
        repeat (31) @(negedge clk);
        checks++;
        if (pll_req !== 1'b0 || clk_en !== 1'b1) begin
            errors++; $display("FAIL up_settle_hold: pll_req/clk_en got %b%b required 01",
                               pll_req, clk_en);
        end
        @(negedge clk);
        checks++;
        if (pll_req !== 1'b1 || clk_en !== 1'b0 || pll_freq !== 32'd600_000_000) begin
            errors++; $display("FAIL up_fchg: got %b%b/%0d required 10/600000000",
                               pll_req, clk_en, pll_freq);
        end
        repeat (9) @(negedge clk);
        checks++;
        if (clk_en !== 1'b0) begin
            errors++; $display("FAIL up_gated: clk_en got %b required 0", clk_en);
        end
        pll_lock = 1'b1;
        @(negedge clk);
        pll_lock = 1'b0;
        checks++;
        if ({vreg_req, pll_req, clk_en, busy, done} !== 5'b00111 || cur_opp !== 3'd3) begin
            errors++; $display("FAIL up_done: got %b/%0d required 00111/3",
                               {vreg_req, pll_req, clk_en, busy, done}, cur_opp);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL up_idle: done/busy got %b%b required 00", done, busy);
        end
    endtask

    task automatic test_down();
        req_opp = 3'd1; req_freq = 32'd300_000_000; req_volt = 16'd650;
        @(negedge clk);
        checks++;
        if ({vreg_req, pll_req, clk_en} !== 3'b010 || vreg_target !== 16'd800 ||
            pll_freq !== 32'd300_000_000) begin
            errors++; $display("FAIL down_pll_first: got %b/%0d/%0d required 010/800/300000000",
                               {vreg_req, pll_req, clk_en}, vreg_target, pll_freq);
        end
        repeat (3) @(negedge clk);
        pll_lock = 1'b1;
        @(negedge clk);
        pll_lock = 1'b0;
        checks++;
        if ({vreg_req, pll_req, clk_en, done} !== 4'b1010 || vreg_target !== 16'd650) begin
            errors++; $display("FAIL down_vreq: got %b/%0d required 1010/650",
                               {vreg_req, pll_req, clk_en, done}, vreg_target);
        end
        vreg_ack = 1'b1;
        @(negedge clk);
        vreg_ack = 1'b0;
        checks++;
        if (done !== 1'b1 || cur_opp !== 3'd1 || vreg_req !== 1'b0) begin
            errors++; $display("FAIL down_done: done/opp/vreq got %b/%0d/%b required 1/1/0",
                               done, cur_opp, vreg_req);
        end
        @(negedge clk);
    endtask

    task automatic test_freq_only();
        logic saw_vreq = 1'b0;
        req_opp = 3'd2; req_freq = 32'd400_000_000; req_volt = 16'd650;
        @(negedge clk);
        saw_vreq |= vreg_req;
        checks++;
        if (pll_req !== 1'b1 || clk_en !== 1'b0) begin
            errors++; $display("FAIL fonly_pll: pll_req/clk_en got %b%b required 10",
                               pll_req, clk_en);
        end
        pll_lock = 1'b1;
        @(negedge clk);
        pll_lock = 1'b0;
        saw_vreq |= vreg_req;
        checks++;
        if (done !== 1'b1 || cur_opp !== 3'd2 || clk_en !== 1'b1 || pll_req !== 1'b0) begin
            errors++; $display("FAIL fonly_done: got %b/%0d/%b/%b required 1/2/1/0",
                               done, cur_opp, clk_en, pll_req);
        end
        @(negedge clk);
        saw_vreq |= vreg_req;
        checks++;
        if (saw_vreq !== 1'b0 || vreg_target !== 16'd650) begin
            errors++; $display("FAIL fonly_no_vreg: got %b/%0d required 0/650",
                               saw_vreq, vreg_target);
        end
    endtask

    task automatic test_mid_change();
        int n = 0;
        req_opp = 3'd4; req_freq = 32'd500_000_000; req_volt = 16'd750;
        @(negedge clk);
        checks++;
        if (vreg_req !== 1'b1) begin
            errors++; $display("FAIL mid_vreq: got %b required 1", vreg_req);
        end
        vreg_ack = 1'b1;
        @(negedge clk);
        vreg_ack = 1'b0;
        req_opp = 3'd5;
        while (pll_req !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 32) begin
            errors++; $display("FAIL mid_settle_len: got %0d cycles required 32", n);
        end
        pll_lock = 1'b1;
        @(negedge clk);
        pll_lock = 1'b0;
        checks++;
        if (done !== 1'b1 || cur_opp !== 3'd4) begin
            errors++; $display("FAIL mid_first_done: done/opp got %b/%0d required 1/4",
                               done, cur_opp);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_gap: done/busy got %b%b required 00", done, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || cur_opp !== 3'd5) begin
            errors++; $display("FAIL mid_second_done: got %b%b/%0d required 11/5",
                               done, busy, cur_opp);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        req_opp = 3'd6; req_freq = 32'd600_000_000; req_volt = 16'd750;
        @(negedge clk);
        checks++;
        if (pll_req !== 1'b1 || clk_en !== 1'b0) begin
            errors++; $display("FAIL to_enter: pll_req/clk_en got %b%b required 10",
                               pll_req, clk_en);
        end
        repeat (2047) @(negedge clk);
        checks++;
        if (fault !== 1'b0 || pll_req !== 1'b1) begin
            errors++; $display("FAIL to_early: fault/pll_req got %b%b required 01", fault, pll_req);
        end
        @(negedge clk);
        checks++;
        if ({fault, pll_req, clk_en, busy} !== 4'b1010 || cur_opp !== 3'd5 ||
            pll_freq !== 32'd600_000_000) begin
            errors++; $display("FAIL to_fault: got %b/%0d/%0d required 1010/5/600000000",
                               {fault, pll_req, clk_en, busy}, cur_opp, pll_freq);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || fault !== 1'b1 || cur_opp !== 3'd5) begin
            errors++; $display("FAIL to_blocked: got %b%b/%0d required 01/5", busy, fault, cur_opp);
        end
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        checks++;
        if (fault !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL to_clear_first: fault/busy got %b%b required 00", fault, busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || done !== 1'b1 || cur_opp !== 3'd6) begin
            errors++; $display("FAIL to_retaken: got %b%b/%0d required 11/6", busy, done, cur_opp);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        req_opp = 3'd7; req_freq = 32'd800_000_000; req_volt = 16'd750;
        @(negedge clk);
        checks++;
        if (pll_req !== 1'b1 || clk_en !== 1'b0 || pll_freq !== 32'd800_000_000) begin
            errors++; $display("FAIL rm_fchg: got %b%b/%0d required 10/800000000",
                               pll_req, clk_en, pll_freq);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({pll_req, clk_en, busy} !== 3'b010 || pll_freq !== 32'd100_000_000 ||
            cur_opp !== 3'd0 || vreg_target !== 16'd700) begin
            errors++; $display("FAIL rm_async: got %b/%0d/%0d/%0d required 010/100000000/0/700",
                               {pll_req, clk_en, busy}, pll_freq, cur_opp, vreg_target);
        end
        req_opp = 3'd0; req_freq = 32'd100_000_000; req_volt = 16'd700;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || clk_en !== 1'b1) begin
            errors++; $display("FAIL rm_release: busy/clk_en got %b%b required 01", busy, clk_en);
        end
    endtask

    initial begin
        test_reset();
        test_up();
        test_down();
        test_freq_only();
        test_mid_change();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
